// File: rtl/gray_compare_monitor.sv
// gray_compare_monitor
//   Compares a Gray-code bus from a counter under test against a reference
//   Gray bus. Once armed by a run of enabled cycles it flags every sampled
//   mismatch, counts mismatches with a saturating counter and captures the
//   first offending pair. With GRAY_STEP_CHECK_EN defined it also flags
//   dut_gray steps that change two or more bits between consecutive samples.
//
// Configuration macro: GRAY_STEP_CHECK_EN (undefined = no step checking,
//   step_err tied low, no previous-value register).
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   enable     in   sample and check the buses this cycle
//   clear      in   synchronous clear of sticky flag, counter and captures
//   dut_gray   in   [WIDTH]  Gray value from the counter under test
//   ref_gray   in   [WIDTH]  Gray value from the reference model
//   err        out  registered mismatch flag, one cycle after the sample
//   err_sticky out  set at first counted mismatch, held until clear/reset
//   err_count  out  [CNT_W] saturating mismatch count
//   first_dut  out  [WIDTH] dut_gray at first counted mismatch
//   first_ref  out  [WIDTH] ref_gray at first counted mismatch
//   step_err   out  registered Gray-step violation on dut_gray
//   armed      out  high while in CHECK
module gray_compare_monitor #(
   parameter int WIDTH = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] dut_gray,
   input  logic [WIDTH-1:0] ref_gray,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_count,
   output logic [WIDTH-1:0] first_dut,
   output logic [WIDTH-1:0] first_ref,
   output logic             step_err,
   output logic             armed
);

   typedef enum logic [1:0] {IDLE, ARM, CHECK} state_t;

   state_t state, state_nxt;
   logic   sample;
   logic   in_check;
   logic   mismatch;

   assign mismatch = (dut_gray != ref_gray);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state: any disabled cycle drops back to IDLE so a new run
   // always re-arms before step checking resumes
   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = ARM;
            ARM:     state_nxt = CHECK;
            CHECK:   state_nxt = CHECK;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // state outputs
   always_comb begin
      armed    = (state == CHECK);
      sample   = enable && (state != IDLE);
      in_check = enable && (state == CHECK);
   end

   // mismatch flag, counter and first-failure capture; clear beats a
   // simultaneous mismatch for the history but err still reports it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err        <= 1'b0;
         err_sticky <= 1'b0;
         err_count  <= '0;
         first_dut  <= '0;
         first_ref  <= '0;
      end else begin
         err <= sample && mismatch;
         if (clear) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
            first_dut  <= '0;
            first_ref  <= '0;
         end else if (sample && mismatch) begin
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
            if (!err_sticky) begin
               err_sticky <= 1'b1;
               first_dut  <= dut_gray;
               first_ref  <= ref_gray;
            end
         end
      end
   end

`ifdef GRAY_STEP_CHECK_EN
   logic [WIDTH-1:0] prev_gray;
   logic [WIDTH-1:0] diff;
   logic             multi_bit;

   // x & (x-1) clears the lowest set bit; nonzero leftover means >= 2 bits
   always_comb begin
      diff      = dut_gray ^ prev_gray;
      multi_bit = (diff & (diff - WIDTH'(1))) != '0;
   end

   // ARM samples only load prev_gray, so a fresh run never checks stale data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_gray <= '0;
         step_err  <= 1'b0;
      end else begin
         step_err <= in_check && multi_bit;
         if (sample) prev_gray <= dut_gray;
      end
   end
`else
   logic unused_check;
   assign unused_check = in_check;
   assign step_err     = 1'b0;
`endif

endmodule

// File: tb/tb_gray_compare_monitor.sv
module tb_gray_compare_monitor;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         reset, enable, clear;
   logic [W-1:0] dut_gray, ref_gray;

   logic         err, err_sticky, step_err, armed;
   logic [7:0]   err_count;
   logic [W-1:0] first_dut, first_ref;

   logic         s_err, s_sticky, s_step, s_armed;
   logic [1:0]   s_count;
   logic [W-1:0] s_fd, s_fr;

   always #5 clk = ~clk;

   gray_compare_monitor #(.WIDTH(W), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .dut_gray(dut_gray), .ref_gray(ref_gray),
      .err(err), .err_sticky(err_sticky), .err_count(err_count),
      .first_dut(first_dut), .first_ref(first_ref),
      .step_err(step_err), .armed(armed));

   // narrow counter copy for saturation
   gray_compare_monitor #(.WIDTH(W), .CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .dut_gray(dut_gray), .ref_gray(ref_gray),
      .err(s_err), .err_sticky(s_sticky), .err_count(s_count),
      .first_dut(s_fd), .first_ref(s_fr),
      .step_err(s_step), .armed(s_armed));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: 'run' = consecutive enabled cycles seen (capped at 2).
   // run>=1 means this enabled cycle is a sample, run>=2 means a checked one.
   int           run;
   bit           m_err, m_step, m_sticky;
   int           m_cnt, m_scnt;
   logic [W-1:0] m_fd, m_fr, m_prev;

   task automatic model_reset();
      run = 0; m_err = 0; m_step = 0; m_sticky = 0;
      m_cnt = 0; m_scnt = 0; m_fd = '0; m_fr = '0; m_prev = '0;
   endtask

   task automatic check_all();
      chk("err",        err,        m_err);
      chk("step_err",   step_err,   m_step);
      chk("err_sticky", err_sticky, m_sticky);
      chk("err_count",  err_count,  m_cnt);
      chk("first_dut",  first_dut,  m_fd);
      chk("first_ref",  first_ref,  m_fr);
      chk("armed",      armed,      run >= 2);
      chk("sat_count",  s_count,    m_scnt);
      chk("sat_err",    s_err,      m_err);
      chk("sat_sticky", s_sticky,   m_sticky);
      chk("sat_step",   s_step,     m_step);
      chk("sat_armed",  s_armed,    run >= 2);
   endtask

   task automatic cyc(input bit en, input bit clr, input logic [W-1:0] d, input logic [W-1:0] r);
      bit smp, chkd, mis;
      enable = en; clear = clr; dut_gray = d; ref_gray = r;
      @(posedge clk);
      smp  = en && run >= 1;
      chkd = en && run >= 2;
      mis  = (d != r);
      m_err = smp && mis;
`ifdef GRAY_STEP_CHECK_EN
      m_step = chkd && ($countones(d ^ m_prev) >= 2);
      if (smp) m_prev = d;
`else
      m_step = 0;
      if (chkd) m_step = 0;
`endif
      if (clr) begin
         m_sticky = 0; m_cnt = 0; m_scnt = 0; m_fd = '0; m_fr = '0;
      end else if (smp && mis) begin
         if (m_cnt < 255) m_cnt++;
         if (m_scnt < 3) m_scnt++;
         if (!m_sticky) begin
            m_sticky = 1; m_fd = d; m_fr = r;
         end
      end
      run = en ? ((run < 2) ? run + 1 : 2) : 0;
      #1 check_all();
   endtask

   function automatic logic [W-1:0] gray(input int i);
      logic [W-1:0] b;
      b = W'(i % 32);
      return b ^ (b >> 1);
   endfunction

   initial begin
      logic [W-1:0] g, d;
      int gi;
      reset = 1'b1; enable = 1'b0; clear = 1'b0; dut_gray = '0; ref_gray = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all();
      reset = 1'b0;

      // idle after reset
      repeat (3) cyc(0, 0, 5'b10101, 5'b01010);

      // matched legal Gray sequence, across the 10000 -> 00000 wrap
      for (int i = 0; i < 40; i++) cyc(1, 0, gray(i), gray(i));
      chk("gray_run_count", err_count, 0);

      // two mismatches two cycles apart
      cyc(1, 0, 5'b00011, 5'b00010);
      cyc(1, 0, 5'b00010, 5'b00010);
      cyc(1, 0, 5'b00110, 5'b00111);
      cyc(1, 0, 5'b00110, 5'b00110);
      chk("two_mis_count", err_count, 2);
      chk("two_mis_fdut",  first_dut, 5'b00011);
      chk("two_mis_fref",  first_ref, 5'b00010);

      // saturation of the 2-bit counter, then clear with a mismatch
      for (int i = 0; i < 5; i++) cyc(1, 0, 5'b11111, 5'b00000);
      chk("sat_hold", s_count, 3);
      cyc(1, 1, 5'b11111, 5'b00000);
      chk("clear_err", err, 1);
      chk("clear_cnt", s_count, 0);
      chk("clear_fd",  first_dut, 0);

      // step 00001 -> 00111 in CHECK, then the same step landing on ARM
      cyc(0, 0, 5'b00001, 5'b00001);
      cyc(1, 0, 5'b00001, 5'b00001);
      cyc(1, 0, 5'b00001, 5'b00001);
      cyc(1, 0, 5'b00001, 5'b00001);
      cyc(1, 0, 5'b00111, 5'b00111);
      cyc(0, 0, 5'b00001, 5'b00001);
      cyc(1, 0, 5'b00001, 5'b00001);
      cyc(1, 0, 5'b00111, 5'b00111);
      chk("arm_no_step", step_err, 0);

      // async reset mid-run with history present
      cyc(1, 0, 5'b00111, 5'b00110);
      cyc(1, 0, 5'b00101, 5'b00100);
      #2 reset = 1'b1;
      #1 model_reset();
      check_all();
      @(posedge clk);
      #1 check_all();
      reset = 1'b0;
      cyc(1, 0, 5'b11111, 5'b11111);
      cyc(1, 0, 5'b11110, 5'b11110);
      chk("post_reset_step", step_err, 0);
      cyc(1, 0, 5'b11110, 5'b11110);

      // randomized: walking Gray reference, occasional faults/clears/gaps
      gi = 0;
      for (int n = 0; n < 400; n++) begin
         g = gray(gi);
         case ($urandom_range(0, 9))
            0:       d = g ^ W'(1 << $urandom_range(0, W - 1));
            1:       d = W'($urandom);
            default: d = g;
         endcase
         cyc($urandom_range(0, 11) != 0, $urandom_range(0, 39) == 0, d, g);
         if ($urandom_range(0, 3) != 0) gi++;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/gray_compare_monitor.md
GRAY_COMPARE_MONITOR -- requirements
Module: gray_compare_monitor

Interface
REQ-001 Parameter WIDTH, default 5: bit width of the compared Gray-code buses.
REQ-002 Parameter CNT_W, default 8: width of the mismatch counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  high = sample and check the buses this cycle.
REQ-006 clear  input  1  synchronous clear of the error history (sticky flag, counter, capture).
REQ-007 dut_gray  input  WIDTH  Gray value from the counter under test.
REQ-008 ref_gray  input  WIDTH  Gray value from the reference model.
REQ-009 err  output  1  registered; high for one cycle after a sampled mismatch.
REQ-010 err_sticky  output  1  set on the first counted mismatch; held until clear or reset.
REQ-011 err_count  output  CNT_W  saturating count of counted mismatches.
REQ-012 first_dut  output  WIDTH  dut_gray captured at the first counted mismatch.
REQ-013 first_ref  output  WIDTH  ref_gray captured at the first counted mismatch.
REQ-014 step_err  output  1  registered; Gray-step violation on dut_gray (see Configuration).
REQ-015 armed  output  1  high while the state machine is in CHECK.

Function
REQ-016 State machine states: IDLE, ARM, CHECK.
- IDLE->ARM when enable=1.
- ARM->CHECK unconditionally on the next cycle.
- ARM or CHECK->IDLE on any cycle with enable=0.
REQ-017 A sample is a cycle with enable=1 in ARM or CHECK.
- Mismatch = dut_gray != ref_gray.
- err is asserted on the cycle after a sampled mismatch; 1-cycle latency.
REQ-018 In IDLE the buses are not compared; err and step_err are 0 on the following cycle.
REQ-019 Each sampled mismatch increments err_count by 1.
- At 2^CNT_W-1 the counter saturates and holds; it never wraps.
REQ-020 On the first counted mismatch while err_sticky=0:
- set err_sticky;
- load first_dut and first_ref.
- Later mismatches do not overwrite first_dut or first_ref.
REQ-021 clear=1 in the same cycle as a mismatch:
- clear wins: err_count, err_sticky, first_dut and first_ref go to 0;
- the mismatch is neither counted nor captured;
- err still asserts for it.
REQ-022 clear does not change the state machine or the previous-value register.
REQ-023 Deasserting enable does not alter err_count, err_sticky or the captures.
REQ-024 armed = 1 exactly when state is CHECK.

Reset
REQ-025 While reset=1:
- state = IDLE;
- err, step_err, err_sticky and armed = 0;
- err_count, first_dut, first_ref and the previous-value register = 0.
REQ-026 Reset mid-operation aborts immediately and asynchronously; no history is retained.
REQ-027 After reset deasserts, the first enable=1 cycle enters ARM; no step check is made against stale data.

Configuration
REQ-028 Macro GRAY_STEP_CHECK_EN.
REQ-029 When GRAY_STEP_CHECK_EN is defined:
- Each sample in ARM or CHECK stores dut_gray in a WIDTH-bit previous-value register.
- For a sample in CHECK, step_err asserts on the next cycle if the Hamming distance between dut_gray and the stored value is 2 or more.
- A distance of 0 (hold) or 1 is legal.
- The wrap from 1 followed by WIDTH-1 zeros to all-zeros is distance 1, so it is legal.
REQ-030 When GRAY_STEP_CHECK_EN is not defined:
- step_err is constant 0;
- no previous-value register exists;
- all other behaviour is identical.

Verification
REQ-031 WIDTH=5, reset pulse, then 3 idle cycles -> all outputs 0; armed=0.
REQ-032 Enable with dut_gray=ref_gray following the legal 5-bit Gray sequence for 40 cycles, including the 10000->00000 wrap -> err=0, step_err=0, err_count=0, armed=1 from the 2nd enabled cycle.
REQ-033 Inject mismatch dut=00011, ref=00010 at one sample, then dut=00110, ref=00111 two cycles later -> err high on each following cycle, err_count=2, err_sticky=1, first_dut=00011, first_ref=00010.
REQ-034 CNT_W=2, inject 5 mismatches -> err_count stays at 3; clear asserted together with a 6th mismatch -> err=1, err_count=0, err_sticky=0, first_dut=first_ref=00000.
REQ-035 With GRAY_STEP_CHECK_EN defined, dut_gray steps 00001->00111 in CHECK -> step_err=1 one cycle later; the same step in the first enabled cycle (ARM) -> step_err=0. Without the macro, the same stimulus -> step_err=0.
REQ-036 Assert reset for 1 cycle mid-sequence with err_count=2 -> all outputs 0 immediately; after release plus enable, the first sample produces no step_err.
